// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM responder: bus widths, counter width and FSM states.
package sram_pkg;

  localparam int unsigned SRAM_DW  = 32;
  localparam int unsigned SRAM_BEW = 4;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_ACTIVE,
    WR_COMMIT
  } sram_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sram_resp_array.sv
// Byte-enabled single-port word store with a registered read port; contents are never reset.
module sram_resp_array
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [SRAM_BEW-1:0]   be,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [SRAM_DW-1:0]    wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [SRAM_DW-1:0]    rdata
);

  logic [SRAM_DW-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < SRAM_BEW; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sram_resp.sv
// Device-side model of an asynchronous SRAM chip: read latency, byte-enabled writes,
// sticky protocol checking and saturating access counters.
module sram_resp
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire  [SRAM_DW-1:0]  ram_data,
  input  logic [ADDR_W-1:0]   ram_addr,
  input  logic [SRAM_BEW-1:0] ram_be_n,
  input  logic                ram_ce_n,
  input  logic                ram_oe_n,
  input  logic                ram_we_n,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    wr_count,
  output logic                proto_err
);

  localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

  sram_state_e         state, state_nxt;
  logic [3:0]          lat_cnt, lat_nxt;
  logic [ADDR_W-1:0]   rd_addr, rd_addr_nxt, wr_addr;
  logic [SRAM_DW-1:0]  wr_data, rd_data;
  logic [SRAM_BEW-1:0] wr_be;
  logic [CNT_W-1:0]    rd_cnt, wr_cnt;
  logic                sel, rd_req, wr_req, addr_moved;
  logic                drive_en, wr_capture, proto_hit, mem_we;

  assign sel        = !ram_ce_n;
  assign rd_req     = sel && !ram_oe_n && ram_we_n;
  assign wr_req     = sel && !ram_we_n;
  assign addr_moved = (ram_addr != rd_addr);

  always_comb begin
    state_nxt   = state;
    lat_nxt     = lat_cnt;
    rd_addr_nxt = rd_addr;
    case (state)
      IDLE: begin
        if (wr_req) begin
          state_nxt = WR_ACTIVE;
        end else if (rd_req) begin
          state_nxt   = RD_WAIT;
          lat_nxt     = LAT_INIT;
          rd_addr_nxt = ram_addr;
        end
      end
      RD_WAIT: begin
        if (!rd_req) begin
          state_nxt = IDLE;
        end else if (addr_moved) begin
          lat_nxt     = LAT_INIT;
          rd_addr_nxt = ram_addr;
        end else if (lat_cnt == 4'd0) begin
          state_nxt = RD_DRIVE;
        end else begin
          lat_nxt = lat_cnt - 4'd1;
        end
      end
      RD_DRIVE: begin
        if (wr_req) begin
          state_nxt = WR_ACTIVE;
        end else if (!rd_req) begin
          state_nxt = IDLE;
        end else if (addr_moved) begin
          state_nxt   = RD_WAIT;
          lat_nxt     = LAT_INIT;
          rd_addr_nxt = ram_addr;
        end
      end
      WR_ACTIVE: begin
        if (!wr_req) state_nxt = WR_COMMIT;
      end
      WR_COMMIT: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Capture also in IDLE/RD_DRIVE so the first write cycle is never lost.
  always_comb begin
    wr_capture = wr_req && (state inside {IDLE, RD_DRIVE, WR_ACTIVE});
    proto_hit  = (sel && !ram_oe_n && !ram_we_n)
              || ((state == WR_ACTIVE) && wr_req
                  && ((ram_addr != wr_addr) || $isunknown(ram_data)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_be     <= '1;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      proto_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      rd_addr <= rd_addr_nxt;
      if (wr_capture) begin
        wr_addr <= ram_addr;
        wr_data <= ram_data;
        wr_be   <= ram_be_n;
      end
      if ((state != RD_DRIVE) && (state_nxt == RD_DRIVE)) rd_cnt <= sat_inc(rd_cnt);
      if ((state == WR_COMMIT) && !(&wr_be)) wr_cnt <= sat_inc(wr_cnt);
      if (proto_hit) proto_err <= 1'b1;
    end
  end

  // A reset landing on the commit cycle must leave the array untouched.
  assign mem_we = (state == WR_COMMIT) && !reset;

  sram_resp_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (~wr_be),
    .waddr(wr_addr[DEPTH_LOG2-1:0]),
    .wdata(wr_data),
    .raddr(rd_addr[DEPTH_LOG2-1:0]),
    .rdata(rd_data)
  );

  assign drive_en = (state == RD_DRIVE);
  assign ram_data = drive_en ? rd_data : 'z;
  assign rd_count = rd_cnt;
  assign wr_count = wr_cnt;

endmodule

// File: tb/tb_sram_resp.sv
// Directed bench for sram_resp: table of write/read vectors plus hand sequences for
// latency, address change, protocol errors, reset mid-write and counter saturation.
module tb_sram_resp;
  import sram_pkg::*;

  localparam int unsigned RD_LAT = 2;

  typedef struct {
    logic        is_wr;
    logic [19:0] a;
    logic [31:0] d;
    logic [3:0]  be_n;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] addr;
  logic [3:0]  be_n;
  logic        ce_n, oe_n, we_n;
  logic        tb_drive;
  logic [31:0] tb_data;
  wire  [31:0] ram_data;
  logic [15:0] rd_count, wr_count;
  logic        proto_err;

  int unsigned n_tests, n_fail;
  int unsigned exp_rd, exp_wr;
  vec_t        vecs[$];

  assign ram_data = tb_drive ? tb_data : 'z;

  sram_resp #(
    .ADDR_W    (20),
    .DEPTH_LOG2(10),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ram_data (ram_data),
    .ram_addr (addr),
    .ram_be_n (be_n),
    .ram_ce_n (ce_n),
    .ram_oe_n (oe_n),
    .ram_we_n (we_n),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pins_idle();
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; tb_drive = 1'b0;
  endtask

  // Counts negedges with the driver off before it turns on; 20 means it never did.
  task automatic wait_drive(output int unsigned off);
    off = 20;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut.drive_en === 1'b1) begin
        off = i;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    addr = a; tb_data = d; be_n = be; tb_drive = 1'b1;
    repeat (2) @(negedge clk);
    pins_idle();
    repeat (2) @(negedge clk);
    if (be != 4'hF) exp_wr++;
  endtask

  task automatic do_read(input logic [19:0] a, input logic [31:0] exp, input string name);
    int unsigned off;
    @(negedge clk);
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = a;
    wait_drive(off);
    check({name, " latency"}, off, RD_LAT);
    check({name, " data"}, ram_data, exp);
    exp_rd++;
    pins_idle();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
  endtask

  initial begin
    int unsigned off;
    n_tests = 0; n_fail = 0; exp_rd = 0; exp_wr = 0;
    reset = 1'b1; addr = '0; be_n = '1; tb_data = '0;
    pins_idle();

    vecs.push_back('{1'b1, 20'h00010, 32'hDEADBEEF, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 20'h00010, 32'h0,        4'h0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 20'h00020, 32'h11223344, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 20'h00020, 32'hAABBCCDD, 4'hA, 32'h0});
    vecs.push_back('{1'b0, 20'h00020, 32'h0,        4'h0, 32'h11BB33DD});
    vecs.push_back('{1'b1, 20'h00021, 32'hCAFEF00D, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 20'h00021, 32'h12345678, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 20'h00021, 32'h0,        4'h0, 32'hCAFEF00D});
    vecs.push_back('{1'b1, 20'h003FF, 32'h01020304, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 20'h003FF, 32'hA0B0C0D0, 4'h6, 32'h0});
    vecs.push_back('{1'b0, 20'h003FF, 32'h0,        4'h0, 32'hA00203D0});
    vecs.push_back('{1'b1, 20'h00400, 32'h55AA55AA, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 20'h00000, 32'h0,        4'h0, 32'h55AA55AA});
    vecs.push_back('{1'b1, 20'h00001, 32'h00000111, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 20'h00002, 32'h00000222, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 20'h00001, 32'h0,        4'h0, 32'h00000111});

    repeat (3) @(negedge clk);
    check("reset rd_count", 32'(rd_count), 32'd0);
    check("reset wr_count", 32'(wr_count), 32'd0);
    check("reset proto_err", 32'(proto_err), 32'd0);
    check("reset driver", 32'(dut.drive_en), 32'd0);
    check("reset state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].d, vecs[i].be_n);
      else do_read(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
    end
    check("table rd_count", 32'(rd_count), exp_rd);
    check("table wr_count", 32'(wr_count), exp_wr);
    check("table proto_err", 32'(proto_err), 32'd0);

    // Address change one cycle into RD_DRIVE restarts the full latency.
    @(negedge clk);
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = 20'h00001;
    wait_drive(off);
    check("addrchg first latency", off, RD_LAT);
    check("addrchg first data", ram_data, 32'h00000111);
    @(negedge clk);
    check("addrchg hold driver", 32'(dut.drive_en), 32'd1);
    addr = 20'h00002;
    wait_drive(off);
    check("addrchg second latency", off, RD_LAT);
    check("addrchg second data", ram_data, 32'h00000222);
    exp_rd += 2;
    pins_idle();
    @(negedge clk);
    check("read release driver", 32'(dut.drive_en), 32'd0);
    check("addrchg rd_count", 32'(rd_count), exp_rd);

    // oe_n and we_n low together: write wins, error flagged, bus never driven.
    @(negedge clk);
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0;
    addr = 20'h00040; tb_data = 32'h0BADF00D; be_n = 4'h0; tb_drive = 1'b1;
    @(negedge clk);
    check("oe+we proto_err", 32'(proto_err), 32'd1);
    check("oe+we driver off", 32'(dut.drive_en), 32'd0);
    @(negedge clk);
    pins_idle();
    repeat (2) @(negedge clk);
    exp_wr++;
    do_read(20'h00040, 32'h0BADF00D, "oe+we commit");
    check("oe+we wr_count", 32'(wr_count), exp_wr);
    check("proto_err sticky", 32'(proto_err), 32'd1);
    pulse_reset();
    check("proto_err after reset", 32'(proto_err), 32'd0);

    // Address moving during WR_ACTIVE is a violation; the last address still commits.
    @(negedge clk);
    ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    addr = 20'h00050; tb_data = 32'h5050A0A0; be_n = 4'h0; tb_drive = 1'b1;
    @(negedge clk);
    check("wr steady proto_err", 32'(proto_err), 32'd0);
    addr = 20'h00051;
    @(negedge clk);
    check("wr addr move proto_err", 32'(proto_err), 32'd1);
    pins_idle();
    repeat (2) @(negedge clk);
    exp_wr++;
    do_read(20'h00051, 32'h5050A0A0, "wr addr move commit");
    pulse_reset();

    // Reset during WR_ACTIVE discards the pending write.
    do_write(20'h00030, 32'h13579BDF, 4'h0);
    pulse_reset();
    @(negedge clk);
    ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    addr = 20'h00030; tb_data = 32'hFFFFFFFF; be_n = 4'h0; tb_drive = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pins_idle();
    check("midwr state", 32'(dut.state), 32'(IDLE));
    check("midwr wr_count", 32'(wr_count), 32'd0);
    @(negedge clk);
    check("midwr state settled", 32'(dut.state), 32'(IDLE));
    do_read(20'h00030, 32'h13579BDF, "midwr mem kept");
    check("midwr wr_count after read", 32'(wr_count), 32'd0);

    // Preload the read counter near its ceiling, then push past it.
    @(negedge clk);
    force dut.rd_cnt = 16'hFFFC;
    @(negedge clk);
    release dut.rd_cnt;
    repeat (2) do_read(20'h00000, 32'h55AA55AA, "sat read");
    check("rd_count near top", 32'(rd_count), 32'h0000FFFE);
    repeat (3) do_read(20'h00400, 32'h55AA55AA, "sat alias read");
    check("rd_count saturated", 32'(rd_count), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_resp.md
Name: sram_resp

Overview:
- Clocked responder model of one external asynchronous SRAM chip (BaseRAM or ExtRAM).
- It is the device end of the ce_n/oe_n/we_n/be_n/addr/data pin interface that the memory arbiter drives.
- Used in simulation and in FPGA loopback builds to close the CPU + arbiter path without the physical chip.
- It adds a configurable read latency, byte-enabled writes, protocol checking and access counters.

Parameters:
- ADDR_W, 20, width of the ram_addr pin bus.
- DEPTH_LOG2, 10, log2 of the words actually stored. Address bits above DEPTH_LOG2 are ignored, so addresses alias.
- RD_LAT, 2, cycles from a read being requested until data is driven. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ram_data  inout  32  data bus. Driven only in RD_DRIVE; high-Z otherwise.
- ram_addr  in  ADDR_W  word address.
- ram_be_n  in  4  byte enables, active low. Bit i covers data[8i+7:8i].
- ram_ce_n  in  1  chip select, active low.
- ram_oe_n  in  1  output enable, active low.
- ram_we_n  in  1  write enable, active low.
- rd_count  out  16  completed reads, saturating.
- wr_count  out  16  committed writes, saturating.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state=IDLE.
  - Data driver disabled (ram_data high-Z).
  - rd_count=0, wr_count=0, proto_err=0.
  - The memory array is NOT reset.
- Sampling: all pin inputs are sampled on the rising edge of clk. No combinational path from any input to ram_data.
- Request decode, from sampled pins:
  - sel = !ce_n.
  - rd_req = sel & !oe_n & we_n.
  - wr_req = sel & !we_n.
  - When oe_n and we_n are both low, the write wins.
- IDLE:
  - wr_req -> WR_ACTIVE.
  - rd_req -> RD_WAIT, with lat_cnt loaded to RD_LAT-1 and rd_addr latched.
  - Otherwise stay in IDLE.
- RD_WAIT:
  - Bus stays high-Z.
  - Each cycle: if !rd_req -> IDLE.
  - Else if the address differs from rd_addr: reload lat_cnt, latch the new address.
  - Else if lat_cnt==0 -> RD_DRIVE.
  - Else lat_cnt-1.
- RD_DRIVE:
  - Drive mem[rd_addr] on ram_data.
  - rd_count increments once on entry.
  - Address change with rd_req still asserted -> RD_WAIT (restarted latency, new address), and the driver turns off that same cycle.
  - !rd_req -> IDLE; the driver turns off on the next edge.
  - wr_req -> WR_ACTIVE; the driver turns off immediately.
- WR_ACTIVE:
  - Bus high-Z.
  - Every cycle with wr_req, latch addr, data and be_n into wr_addr/wr_data/wr_be. The last sampled values win.
  - Leave when wr_req drops, i.e. we_n rises or ce_n rises -> WR_COMMIT.
- WR_COMMIT (one cycle):
  - For each byte i with wr_be[i]==0, write mem[wr_addr] byte i = wr_data byte i.
  - wr_count increments only if at least one byte is enabled.
  - Next state: IDLE. The pins are not re-examined in this cycle, so the gap between accesses is at least one cycle.
- Read after write: a read of the address just committed returns the new data. The commit completes before RD_WAIT can start.
- proto_err is set, and stays set until reset, when any of these happens:
  - oe_n and we_n are both low while ce_n is low.
  - The address changes during WR_ACTIVE.
  - ram_data reads X/Z in WR_ACTIVE (simulation builds only).
- Counters saturate at 16'hFFFF and do not wrap.
- Reset mid-operation: a pending write is discarded (mem is unchanged), the driver is released in the same edge, and the FSM returns to IDLE.
- ce_n high overrides oe_n and we_n in every state.

Decomposition:
- Shared package sram_pkg:
  - State enum: IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE, WR_COMMIT.
  - SRAM_DW=32, SRAM_BEW=4.
  - CNT_W=16.
  - Shared with z_stage so both ends use the same data and byte widths.
- One natural sub-module: sram_resp_array, the byte-enabled single-port memory (write port plus registered read port).
- The FSM, counters and tri-state control stay in sram_resp.

Test Plan:
- Single read: with mem[0x010]=32'hDEADBEEF, hold ce_n=0, oe_n=0, we_n=1, addr=0x010 → ram_data stays high-Z for RD_LAT cycles and then shows DEADBEEF; rd_count=1.
- Byte-enabled write: with mem[0x020]=0x11223344, pulse we_n low for 2 cycles with data=0xAABBCCDD and be_n=4'b1010, then read 0x020 → reads 0x11BB33DD; wr_count=1.
- Address change during a read: read 0x001, then switch to 0x002 after 1 cycle of RD_DRIVE → the bus goes high-Z for RD_LAT cycles, then mem[0x002] appears; rd_count=2.
- Protocol violation: assert oe_n=0 and we_n=0 with ce_n=0 → proto_err=1, the bus stays high-Z and the write commits; after reset, proto_err=0.
- Reset mid-write: we_n low with data=0xFFFFFFFF at address 0x030, reset for 1 cycle → mem[0x030] unchanged, wr_count=0, state IDLE.
- Aliasing and saturation: with DEPTH_LOG2=10, write address 0x00400 and read address 0x00000 → same data. Force 65540 reads → rd_count=16'hFFFF.
